// File: rtl/cmd_resp_uart.sv
// cmd_resp_uart: UART RX -> 16-bit command assembler, 1-byte response TX.
// Optional macro CMD_TIMEOUT_EN drops a stale high byte after TIMEOUT_CLKS.
module cmd_resp_uart #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned TIMEOUT_CLKS = 500000
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic        resp_pos,
  output logic        resp_busy,
  output logic        resp_sent
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 16 || TIMEOUT_CLKS < 1) begin : g_cfg_chk
    $error("cmd_resp_uart: bad parameters");
  end

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  typedef enum logic {A_HIGH, A_LOW} asm_st_e;
  typedef enum logic {T_IDLE, T_TXING} tx_st_e;

  // rx_s3_q keeps the previous synced level for start-edge detection
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          byte_vld;
  logic          start_det;

  asm_st_e       asm_q, asm_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          rdy_q, rdy_d;

  tx_st_e        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          sent;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  assign start_det = !rx_s2_q && rx_s3_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    byte_vld = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (start_det) rx_st_d = R_START;
      end
      R_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == FULL) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end
      R_STOP: if (rx_cnt_q == FULL) begin
        byte_vld = rx_s2_q;
        rx_st_d  = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_comb begin
    asm_d = asm_q;
    hi_d  = hi_q;
    cmd_d = cmd_q;
    rdy_d = rdy_q && !clr_cmd_rdy;
`ifdef CMD_TIMEOUT_EN
    to_d  = '0;
`endif
    if (byte_vld) begin
      unique case (asm_q)
        A_HIGH: begin
          hi_d  = rx_sh_q;
          rdy_d = 1'b0;
          asm_d = A_LOW;
        end
        A_LOW: begin
          cmd_d = {hi_q, rx_sh_q};
          rdy_d = 1'b1;
          asm_d = A_HIGH;
        end
        default: asm_d = A_HIGH;
      endcase
    end
`ifdef CMD_TIMEOUT_EN
    // counter holds once a start bit is in flight; an arriving start wins a tie
    if (asm_q == A_LOW) begin
      to_d = to_q;
      if (rx_st_q == R_IDLE && !start_det) begin
        to_d = to_q + TW'(1);
        if (to_q == TW'(TIMEOUT_CLKS - 1)) begin
          to_d  = '0;
          asm_d = A_HIGH;
        end
      end
    end
`endif
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    sent     = 1'b0;
    unique case (tx_st_q)
      T_IDLE: begin
        tx_d = 1'b1;
        if (send_resp) begin
          tx_st_d  = T_TXING;
          tx_sh_d  = {1'b1, resp_pos ? 8'hA5 : 8'h5A};
          tx_d     = 1'b0;
          tx_cnt_d = '0;
          tx_bit_d = '0;
        end
      end
      T_TXING: begin
        tx_cnt_d = tx_cnt_q + CW'(1);
        if (tx_cnt_q == FULL) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_st_d = T_IDLE;
            tx_d    = 1'b1;
            sent    = 1'b1;
          end else begin
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b1, tx_sh_q[8:1]};
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= R_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      asm_q    <= A_HIGH;
      hi_q     <= '0;
      cmd_q    <= '0;
      rdy_q    <= 1'b0;
      tx_st_q  <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
`ifdef CMD_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      rx_s1_q  <= RX;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      asm_q    <= asm_d;
      hi_q     <= hi_d;
      cmd_q    <= cmd_d;
      rdy_q    <= rdy_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
`ifdef CMD_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = rdy_q;
  assign resp_busy = (tx_st_q == T_TXING);
  assign resp_sent = sent;

endmodule

// File: tb/tb_cmd_resp_uart.sv
// tb_cmd_resp_uart: directed bench with a host-side UART driver and monitor.
// Compile with +define+CMD_TIMEOUT_EN to exercise the timeout build.
module tb_cmd_resp_uart;

  localparam int CPB    = 16;
  localparam int TO     = 500;
  localparam int BIT_NS = CPB * 10;

  logic        clk = 1'b0;
  logic        RST_n, RX, TX;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, send_resp, resp_pos;
  logic        resp_busy, resp_sent;

  int checks = 0;
  int failures = 0;

  cmd_resp_uart #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .RST_n(RST_n), .RX(RX), .TX(TX),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp_pos(resp_pos),
    .resp_busy(resp_busy), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  int   rdy_rises = 0;
  int   sent_cnt = 0;
  logic rdy_p = 1'b0;
  always @(posedge clk) begin
    rdy_p <= cmd_rdy;
    if (cmd_rdy && !rdy_p) rdy_rises <= rdy_rises + 1;
    if (resp_sent) sent_cnt <= sent_cnt + 1;
  end

  // host receiver: mid-bit sampling of TX
  logic [7:0] hq[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TX);
      #(BIT_NS / 2 + 2);
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        b[i] = TX;
      end
      #(BIT_NS);
      hq.push_back(b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    RX = v;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    RX = 1'b1;
    tick(4);
  endtask

  task automatic pulse_resp(input logic p);
    send_resp = 1'b1;
    resp_pos  = p;
    tick(1);
    send_resp = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        do_clr;
    logic [15:0] exp;
  } cmd_vec_t;

  typedef struct {
    logic       pos;
    logic [7:0] exp;
  } resp_vec_t;

  initial begin
    cmd_vec_t  cv[4];
    resp_vec_t rv[3];
    int        k, r0, s0;

    cv[0] = '{b0: 8'h20, b1: 8'h00, do_clr: 1'b1, exp: 16'h2000};
    cv[1] = '{b0: 8'hA5, b1: 8'h5A, do_clr: 1'b0, exp: 16'hA55A};
    cv[2] = '{b0: 8'h01, b1: 8'hFF, do_clr: 1'b1, exp: 16'h01FF};
    cv[3] = '{b0: 8'hFF, b1: 8'h00, do_clr: 1'b1, exp: 16'hFF00};
    rv[0] = '{pos: 1'b0, exp: 8'h5A};
    rv[1] = '{pos: 1'b1, exp: 8'hA5};
    rv[2] = '{pos: 1'b0, exp: 8'h5A};

    RST_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp_pos = 1'b0;
    tick(3);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 0);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_busy", resp_busy, 0);
    chk("rst_sent", resp_sent, 0);
    RST_n = 1'b1;
    tick(4);

    for (int i = 0; i < 4; i++) begin
      r0 = rdy_rises;
      send_byte(cv[i].b0, 1'b1);
      chk($sformatf("v%0d_rdy_hi", i), cmd_rdy, 0);
      send_byte(cv[i].b1, 1'b1);
      chk($sformatf("v%0d_cmd", i), cmd, cv[i].exp);
      chk($sformatf("v%0d_rdy", i), cmd_rdy, 1);
      chk($sformatf("v%0d_rises", i), rdy_rises - r0, 1);
      if (cv[i].do_clr) begin
        pulse_clr();
        chk($sformatf("v%0d_clr", i), cmd_rdy, 0);
      end
    end

    for (int i = 0; i < 3; i++) begin
      hq.delete();
      pulse_resp(rv[i].pos);
      chk($sformatf("r%0d_busy", i), resp_busy, 1);
      k = 1;
      while (resp_sent !== 1'b1 && k < 20 * CPB) begin
        tick(1);
        k++;
      end
      chk($sformatf("r%0d_lat", i), k, 10 * CPB);
      tick(1);
      chk($sformatf("r%0d_pulse", i), resp_sent, 0);
      chk($sformatf("r%0d_idle", i), resp_busy, 0);
      chk($sformatf("r%0d_n", i), hq.size(), 1);
      if (hq.size() > 0) chk($sformatf("r%0d_byte", i), hq[0], rv[i].exp);
    end

    // short RX glitch must not start a frame
    r0 = rdy_rises;
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    tick(3 * CPB);
    send_byte(8'h40, 1'b1);
    send_byte(8'h02, 1'b1);
    chk("glitch_cmd", cmd, 16'h4002);
    chk("glitch_rises", rdy_rises - r0, 1);
    pulse_clr();

    // framing error on the low byte
    r0 = rdy_rises;
    send_byte(8'h77, 1'b1);
    send_byte(8'h99, 1'b0);
    chk("ferr_rdy", cmd_rdy, 0);
    chk("ferr_cmd", cmd, 16'h4002);
    send_byte(8'h33, 1'b1);
    chk("ferr_cmd2", cmd, 16'h7733);
    chk("ferr_rises", rdy_rises - r0, 1);
    pulse_clr();

    // clear coinciding with completion: set wins
    send_byte(8'h55, 1'b1);
    clr_cmd_rdy = 1'b1;
    fork
      send_byte(8'h66, 1'b1);
      begin
        k = 0;
        while (cmd !== 16'h5566 && k < 20 * CPB) begin
          tick(1);
          k++;
        end
        chk("setwin_rdy", cmd_rdy, 1);
        tick(1);
        chk("setwin_clr", cmd_rdy, 0);
      end
    join
    clr_cmd_rdy = 1'b0;
    chk("setwin_cmd", cmd, 16'h5566);

    // send_resp while busy is dropped
    hq.delete();
    s0 = sent_cnt;
    pulse_resp(1'b1);
    tick(50);
    pulse_resp(1'b0);
    tick(22 * CPB);
    chk("busy_frames", hq.size(), 1);
    if (hq.size() > 0) chk("busy_byte", hq[0], 8'hA5);
    chk("busy_sent", sent_cnt - s0, 1);

    // reset in the middle of a frame
    pulse_resp(1'b1);
    tick(40);
    chk("mid_busy", resp_busy, 1);
    RST_n = 1'b0;
    tick(1);
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_busy", resp_busy, 0);
    chk("mid_rst_cmd", cmd, 0);
    RST_n = 1'b1;
    tick(12 * CPB);
    hq.delete();

    // stale high byte
    send_byte(8'h12, 1'b1);
    tick(TO + 100);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
`ifdef CMD_TIMEOUT_EN
    chk("to_cmd", cmd, 16'h3456);
    chk("to_rdy", cmd_rdy, 1);
`else
    chk("to_cmd", cmd, 16'h1234);
    chk("to_rdy", cmd_rdy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
